// File: rtl/drac_pkg.sv
// Shared exe-stage definitions: multiplier latencies and the issue-scheduler queue entry.
package drac_pkg;

  localparam int MUL_LAT_32    = 1;
  localparam int MUL_LAT_64    = 2;
  localparam int MUL_PAYLOAD_W = 64;

  typedef struct packed {
    logic                     op32;
    logic [MUL_PAYLOAD_W-1:0] payload;
  } mul_sched_entry_t;

endpackage

// File: rtl/mul_sched_fifo.sv
// Circular request buffer for the multiplier issue scheduler (DEPTH must be a power of two, >= 2).
module mul_sched_fifo
  import drac_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = mul_sched_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   flush,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  entry_t           mem [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mul_issue_sched.sv
// Issue scheduler for the 2-stage multiplier: one issue per cycle, no result-port collisions.
// Optional perf counters (stall_cnt_o, issue_cnt_o) are built when MUL_SCHED_PERF_EN is defined.
module mul_issue_sched
  import drac_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 kill_i,
  input  logic                 req_valid_i,
  input  logic                 req_op32_i,
  input  logic [PAYLOAD_W-1:0] req_payload_i,
  output logic                 req_ready_o,
  output logic                 mul_valid_o,
  output logic                 mul_op32_o,
  output logic [PAYLOAD_W-1:0] mul_payload_o,
  output logic                 wb_valid_o,
  output logic [1:0]           inflight_o,
  output logic                 idle_o
`ifdef MUL_SCHED_PERF_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          issue_cnt_o
`endif
);

  typedef struct packed {
    logic                 op32;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t                push_data;
  entry_t                head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  head_ok;
  logic                  vld_p0;
  logic [MUL_LAT_64-1:0] resv;
  logic [MUL_LAT_64-1:0] resv_next;
  logic [1:0]            inflight_q;

  assign req_ready_o       = ~full;
  assign push              = req_valid_i & ~full & ~kill_i;
  assign push_data.op32    = req_op32_i;
  assign push_data.payload = req_payload_i;

  mul_sched_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (kill_i),
    .push  (push),
    .wdata (push_data),
    .pop   (vld_p0),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Issue stage (p0): a 32-bit op may not land on the slot a 64-bit op reserved last cycle.
  assign head_ok = ~empty & ~(head.op32 & resv[MUL_LAT_64-1]);
  assign vld_p0  = head_ok & ~kill_i;

  assign mul_valid_o   = vld_p0;
  assign mul_op32_o    = vld_p0 & head.op32;
  assign mul_payload_o = vld_p0 ? head.payload : '0;

  always_comb begin
    resv_next                 = '0;
    resv_next[MUL_LAT_32-1]   = resv[MUL_LAT_64-1] | (vld_p0 & head.op32);
    resv_next[MUL_LAT_64-1]   = vld_p0 & ~head.op32;
  end

  // Result slot reservation: bit 0 is the writeback slot of the coming cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resv <= '0;
    end else if (kill_i) begin
      resv <= '0;
    end else begin
      resv <= resv_next;
    end
  end

  assign wb_valid_o = resv[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else if (kill_i) begin
      inflight_q <= '0;
    end else begin
      case ({vld_p0, wb_valid_o})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign inflight_o = inflight_q;
  assign idle_o     = empty & (inflight_q == 2'd0);

`ifdef MUL_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Perf counters survive kill so flush-heavy phases remain visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      issue_cnt_o <= '0;
    end else begin
      if (~empty & ~head_ok) stall_cnt_o <= sat_inc(stall_cnt_o);
      if (vld_p0)            issue_cnt_o <= sat_inc(issue_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_mul_issue_sched.sv
// Self-checking bench for mul_issue_sched: result-slot model plus directed scenarios.
module tb_mul_issue_sched;

  localparam int DEPTH = 4;
  localparam int PW    = 64;

  bit            clk;
  logic          rst         = 1'b1;
  logic          kill        = 1'b0;
  logic          req_valid   = 1'b0;
  logic          req_op32    = 1'b0;
  logic [PW-1:0] req_payload = '0;
  logic          req_ready;
  logic          mul_valid;
  logic          mul_op32;
  logic [PW-1:0] mul_payload;
  logic          wb_valid;
  logic [1:0]    inflight;
  logic          idle;
`ifdef MUL_SCHED_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   issue_cnt;
`endif

  int nchk = 0;
  int nerr = 0;

  mul_issue_sched #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .kill_i        (kill),
    .req_valid_i   (req_valid),
    .req_op32_i    (req_op32),
    .req_payload_i (req_payload),
    .req_ready_o   (req_ready),
    .mul_valid_o   (mul_valid),
    .mul_op32_o    (mul_op32),
    .mul_payload_o (mul_payload),
    .wb_valid_o    (wb_valid),
    .inflight_o    (inflight),
    .idle_o        (idle)
`ifdef MUL_SCHED_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .issue_cnt_o   (issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a plain FIFO of ops and the list of cycles on which a result will appear.
  typedef struct {
    bit            op32;
    logic [PW-1:0] payload;
  } op_t;

  op_t q[$];
  int  wb_at[$];
  int  mcyc    = 0;
  int  m_stall = 0;
  int  m_issue = 0;

  function automatic bit has_wb(int c);
    foreach (wb_at[i]) if (wb_at[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin : model
    bit   exp_ready, exp_issue, blocked;
    int   lat;
    int   keep[$];
    op_t  e;
    if (rst) begin
      q.delete();
      wb_at.delete();
      m_stall = 0;
      m_issue = 0;
      chk("rst_ready", req_ready, 1);
      chk("rst_mul_valid", mul_valid, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_idle", idle, 1);
      chk("rst_payload", mul_payload, 0);
      chk("rst_op32", mul_op32, 0);
    end else begin
      exp_ready = (q.size() < DEPTH);
      blocked   = 1'b0;
      if (q.size() > 0) begin
        lat     = q[0].op32 ? 1 : 2;
        blocked = has_wb(mcyc + lat);
      end
      exp_issue = (q.size() > 0) && !blocked && !kill;
      chk("m_ready", req_ready, exp_ready);
      chk("m_mul_valid", mul_valid, exp_issue);
      chk("m_wb_valid", wb_valid, has_wb(mcyc));
      chk("m_inflight", inflight, wb_at.size());
      chk("m_idle", idle, (q.size() == 0) && (wb_at.size() == 0));
      if (exp_issue) begin
        chk("m_op32", mul_op32, q[0].op32);
        chk("m_payload", mul_payload, q[0].payload);
      end else begin
        chk("m_op32_gated", mul_op32, 0);
        chk("m_payload_gated", mul_payload, 0);
      end
`ifdef MUL_SCHED_PERF_EN
      chk("m_stall_cnt", stall_cnt, m_stall);
      chk("m_issue_cnt", issue_cnt, m_issue);
`endif
      if (q.size() > 0 && blocked) m_stall++;
      if (exp_issue) m_issue++;
      if (kill) begin
        q.delete();
        wb_at.delete();
      end else begin
        if (exp_issue) begin
          wb_at.push_back(mcyc + lat);
          void'(q.pop_front());
        end
        if (req_valid && exp_ready) begin
          e.op32    = req_op32;
          e.payload = req_payload;
          q.push_back(e);
        end
      end
      keep.delete();
      foreach (wb_at[i]) if (wb_at[i] > mcyc) keep.push_back(wb_at[i]);
      wb_at = keep;
    end
    mcyc++;
  end

  task automatic push_op(input bit op32, input logic [PW-1:0] pl);
    req_valid   = 1'b1;
    req_op32    = op32;
    req_payload = pl;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    req_valid = 1'b0;
    while (idle !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(nm, (n < 50), 1);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int   got[$];
    bit   saw_full;
    int   i;
    int   guard;
    bit   l5[9];
`ifdef MUL_SCHED_PERF_EN
    logic [31:0] s0, i0;
`endif
    repeat (3) tick();
    chk("reset_ready", req_ready, 1);
    chk("reset_idle", idle, 1);
    rst = 1'b0;
    tick();

    // Single 64-bit op: issue at +1, writeback at +3, idle at +4.
    push_op(1'b0, 64'hA);
    #3 chk("t1_ready", req_ready, 1);
    tick(); req_valid = 1'b0;
    #3 chk("t1_issue", mul_valid, 1);
    chk("t1_payload", mul_payload, 64'hA);
    tick(); #3 chk("t1_infl_c2", inflight, 1);
    chk("t1_wb_c2", wb_valid, 0);
    tick(); #3 chk("t1_wb_c3", wb_valid, 1);
    chk("t1_infl_c3", inflight, 1);
    tick(); #3 chk("t1_infl_c4", inflight, 0);
    chk("t1_idle_c4", idle, 1);
    wait_idle("t1_drain");

    // 64-bit then 32-bit: the 32-bit op is held one cycle.
    push_op(1'b0, 64'hB0);
    tick(); push_op(1'b1, 64'hB1);
    #3 chk("t2_issue_a", mul_valid, 1);
    chk("t2_payload_a", mul_payload, 64'hB0);
    tick(); req_valid = 1'b0;
    #3 chk("t2_hold_b", mul_valid, 0);
    tick(); #3 chk("t2_issue_b", mul_valid, 1);
    chk("t2_payload_b", mul_payload, 64'hB1);
    chk("t2_wb_c3", wb_valid, 1);
    tick(); #3 chk("t2_wb_c4", wb_valid, 1);
    tick(); #3 chk("t2_wb_c5", wb_valid, 0);
    wait_idle("t2_drain");

    // Back-to-back 32-bit stream.
`ifdef MUL_SCHED_PERF_EN
    s0 = stall_cnt;
    i0 = issue_cnt;
`endif
    for (int k = 0; k < 9; k++) begin
      if (k < 8) push_op(1'b1, 64'h30 + 64'(k));
      else req_valid = 1'b0;
      #3;
      chk("t3_ready", req_ready, 1);
      if (k > 0) begin
        chk("t3_issue", mul_valid, 1);
        chk("t3_payload", mul_payload, 64'h30 + 64'(k - 1));
      end
      tick();
    end
    wait_idle("t3_drain");
`ifdef MUL_SCHED_PERF_EN
    chk("t3_stall_cnt", stall_cnt - s0, 0);
    chk("t3_issue_cnt", issue_cnt - i0, 8);
`endif

    // Alternating 64/32 backs the FIFO up; 10 ops exercise pointer wrap.
    saw_full = 1'b0;
    i        = 0;
    guard    = 0;
    while ((i < 10 || got.size() < 10) && guard < 300) begin
      if (i < 10) push_op((i % 2) == 1, 64'(i));
      else req_valid = 1'b0;
      #3;
      if (mul_valid === 1'b1) got.push_back(int'(mul_payload));
      if (req_ready === 1'b0) saw_full = 1'b1;
      if (i < 10 && req_ready === 1'b1) i++;
      tick();
      guard++;
    end
    req_valid = 1'b0;
    chk("t4_bounded", (guard < 300), 1);
    chk("t4_saw_full", saw_full, 1);
    chk("t4_count", got.size(), 10);
    foreach (got[k]) chk("t4_order", got[k], k);
    wait_idle("t4_drain");

    // Kill with 3 queued, 2 in flight, and a push in the same cycle.
    l5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 9; k++) begin
      push_op(l5[k], 64'h50 + 64'(k));
      tick();
    end
    push_op(1'b0, 64'h5F);
    kill = 1'b1;
    #3 chk("t5_infl_before", inflight, 2);
    chk("t5_kill_no_issue", mul_valid, 0);
    tick();
    kill      = 1'b0;
    req_valid = 1'b0;
    #3 chk("t5_infl_after", inflight, 0);
    chk("t5_wb_after", wb_valid, 0);
    chk("t5_idle_after", idle, 1);
    chk("t5_ready_after", req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      #3 chk("t5_killed_silent", mul_valid, 0);
    end
    wait_idle("t5_drain");

    // Asynchronous reset while ops are in flight.
    push_op(1'b0, 64'h60);
    tick(); push_op(1'b0, 64'h61);
    tick(); req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_ready", req_ready, 1);
    chk("t6_mul_valid", mul_valid, 0);
    chk("t6_wb", wb_valid, 0);
    chk("t6_inflight", inflight, 0);
    chk("t6_idle", idle, 1);
    chk("t6_payload", mul_payload, 0);
    tick();
    rst = 1'b0;
    push_op(1'b1, 64'h77);
    #3 chk("t6_no_issue_yet", mul_valid, 0);
    tick(); req_valid = 1'b0;
    #3 chk("t6_issue", mul_valid, 1);
    chk("t6_issue_payload", mul_payload, 64'h77);
    chk("t6_issue_op32", mul_op32, 1);
    wait_idle("t6_drain");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
